// File: rtl/sine_dac_seq_pkg.sv
// ============================================================================
// sine_dac_seq_pkg : FSM state type, default widths/command and sine quarter-wave table
// Rev 1.0
// ============================================================================
`default_nettype none

package sine_dac_seq_pkg;

   localparam int         SDS_ADDR_W = 8;
   localparam int         SDS_DATA_W = 12;
   localparam int         SDS_PER_W  = 16;
   localparam logic [3:0] SDS_CMD    = 4'b0011;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      FETCH    = 3'd2,
      START    = 3'd3,
      WAIT_EOW = 3'd4,
      HOLD     = 3'd5
   } state_t;

   // round(2047.5 + 2047.5*sin(2*pi*k/256)) for k = 0..64
   localparam logic [11:0] SINE_QUARTER [0:64] = '{
      12'd2048, 12'd2098, 12'd2148, 12'd2198, 12'd2248, 12'd2298, 12'd2348, 12'd2398,
      12'd2447, 12'd2496, 12'd2545, 12'd2594, 12'd2642, 12'd2690, 12'd2737, 12'd2784,
      12'd2831, 12'd2877, 12'd2923, 12'd2968, 12'd3013, 12'd3057, 12'd3100, 12'd3143,
      12'd3185, 12'd3226, 12'd3267, 12'd3307, 12'd3346, 12'd3385, 12'd3423, 12'd3459,
      12'd3495, 12'd3530, 12'd3565, 12'd3598, 12'd3630, 12'd3662, 12'd3692, 12'd3722,
      12'd3750, 12'd3777, 12'd3804, 12'd3829, 12'd3853, 12'd3876, 12'd3898, 12'd3919,
      12'd3939, 12'd3958, 12'd3975, 12'd3992, 12'd4007, 12'd4021, 12'd4034, 12'd4045,
      12'd4056, 12'd4065, 12'd4073, 12'd4080, 12'd4085, 12'd4089, 12'd4093, 12'd4094,
      12'd4095
   };

   // Lower half mirrors the upper half around 2047.5; k=128 is the exact midpoint tie.
   function automatic logic [11:0] sine_value(input logic [7:0] k);
      logic [6:0]  fwd;
      logic [6:0]  rev;
      logic [11:0] val;
      fwd = {1'b0, k[5:0]};
      rev = 7'd64 - fwd;
      case (k[7:6])
         2'd0:    val = SINE_QUARTER[fwd];
         2'd1:    val = SINE_QUARTER[rev];
         2'd2:    val = (k == 8'd128) ? 12'd2048 : 12'd4095 - SINE_QUARTER[fwd];
         default: val = 12'd4095 - SINE_QUARTER[rev];
      endcase
      return val;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sine_rom.sv
// ============================================================================
// sine_rom : 256 x 12 full-period sine table, synchronous read, 1-cycle latency
// Rev 1.0
// ============================================================================
`default_nettype none

module sine_rom
   import sine_dac_seq_pkg::*;
#(
   parameter int AddrW = SDS_ADDR_W,
   parameter int DataW = SDS_DATA_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [AddrW-1:0] addr,
   output logic [DataW-1:0] data
);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         data <= '0;
      end else begin
         data <= DataW'(sine_value(8'(addr)));
      end
   end

endmodule

`default_nettype wire

// File: rtl/sine_dac_seq.sv
// ============================================================================
// sine_dac_seq : paced sine sample sequencer feeding an SPI DAC writer
// Rev 1.0 -- optional amplitude scaling port amp_i via SINE_DAC_SEQ_AMP_EN
// ============================================================================
`default_nettype none

module sine_dac_seq
   import sine_dac_seq_pkg::*;
#(
   parameter int         AddrW = SDS_ADDR_W,
   parameter int         DataW = SDS_DATA_W,
   parameter int         PerW  = SDS_PER_W,
   parameter logic [3:0] Cmd   = SDS_CMD
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [AddrW-1:0] step_i,
   input  logic [PerW-1:0]  period_i,
   input  logic             eow_i,
`ifdef SINE_DAC_SEQ_AMP_EN
   input  logic [1:0]       amp_i,
`endif
   output logic [15:0]      din_o,
   output logic             strw_o,
   output logic             busy_o
);

   state_t           state;
   state_t           state_nx;
   logic [AddrW-1:0] phase;
   logic [PerW-1:0]  cnt;
   logic [PerW-1:0]  period_q;
   logic [PerW-1:0]  hold_thresh;
   logic [DataW-1:0] rom_data;
   logic [DataW-1:0] sample;

   sine_rom #(
      .AddrW (AddrW),
      .DataW (DataW)
   ) u_rom (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .addr  (phase),
      .data  (rom_data)
   );

`ifdef SINE_DAC_SEQ_AMP_EN
   localparam logic signed [DataW:0] MID = {2'b01, {(DataW-1){1'b0}}};
   logic signed [DataW:0] centered;
   assign centered = $signed({1'b0, rom_data}) - MID;
   assign sample   = DataW'((centered >>> amp_i) + MID);
`else
   assign sample = rom_data;
`endif

   // LOAD+FETCH+START take three cycles after HOLD, so HOLD releases at P-3;
   // short periods collapse to the minimum loop, which the eow wait already exceeds.
   assign hold_thresh = (period_q < PerW'(4)) ? PerW'(1) : period_q - PerW'(3);

   always_comb begin
      state_nx = state;
      strw_o   = 1'b0;
      busy_o   = 1'b1;
      case (state)
         IDLE: begin
            busy_o = 1'b0;
            if (en_i) state_nx = LOAD;
         end
         LOAD:     state_nx = FETCH;
         FETCH:    state_nx = START;
         START: begin
            strw_o   = 1'b1;
            state_nx = WAIT_EOW;
         end
         WAIT_EOW: if (eow_i) state_nx = HOLD;
         HOLD: begin
            if (!en_i)                   state_nx = IDLE;
            else if (cnt >= hold_thresh) state_nx = LOAD;
         end
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         phase    <= '0;
         cnt      <= '0;
         period_q <= '0;
         din_o    <= 16'h0000;
      end else begin
         if (state_nx == IDLE) begin
            phase <= '0;
         end else if (state == START) begin
            phase <= phase + step_i;
         end
         // Cleared on leaving FETCH so the counter reads 0 during START.
         if (state == FETCH) begin
            cnt <= '0;
         end else if (cnt != '1) begin
            cnt <= cnt + PerW'(1);
         end
         if (state == START) begin
            period_q <= period_i;
         end
         if (state == FETCH) begin
            din_o <= {Cmd, sample};
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sine_dac_seq.sv
// ============================================================================
// tb_sine_dac_seq : directed self-checking bench for sine_dac_seq
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sine_dac_seq;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        en_i;
   logic [7:0]  step_i;
   logic [15:0] period_i;
   logic        eow_i;
`ifdef SINE_DAC_SEQ_AMP_EN
   logic [1:0]  amp_i;
`endif
   logic [15:0] din_o;
   logic        strw_o;
   logic        busy_o;

   int n_cmp     = 0;
   int n_bad     = 0;
   int cyc       = 0;
   bit auto_eow  = 1'b0;
   int eow_delay = 20;
   int eow_timer = 0;

   sine_dac_seq dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .en_i     (en_i),
      .step_i   (step_i),
      .period_i (period_i),
      .eow_i    (eow_i),
`ifdef SINE_DAC_SEQ_AMP_EN
      .amp_i    (amp_i),
`endif
      .din_o    (din_o),
      .strw_o   (strw_o),
      .busy_o   (busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // SPI writer stand-in: raises eow_i for one cycle, eow_delay cycles after strw_o.
   always begin
      @(posedge clk);
      #1;
      if (auto_eow) begin
         if (eow_timer > 0) begin
            eow_timer--;
            eow_i = (eow_timer == 0);
         end else begin
            eow_i = 1'b0;
         end
         if (strw_o === 1'b1) eow_timer = eow_delay;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_strw(input string tag, output int at);
      int k;
      k = 0;
      tick();
      while (strw_o !== 1'b1 && k < 400) begin
         tick();
         k++;
      end
      check({tag, "_seen"}, {31'd0, strw_o}, 32'd1);
      at = cyc;
   endtask

   initial begin
      int t0;
      int t1;
      int seen;
      logic [15:0] exp_q [0:4];
      exp_q[0] = 16'h3800;
      exp_q[1] = 16'h3FFF;
      exp_q[2] = 16'h3800;
      exp_q[3] = 16'h3000;
      exp_q[4] = 16'h3800;

      rst_i    = 1'b0;
      en_i     = 1'b0;
      eow_i    = 1'b0;
      step_i   = 8'd1;
      period_i = 16'd100;
`ifdef SINE_DAC_SEQ_AMP_EN
      amp_i    = 2'd0;
`endif
      tick(2);
      check("rst_din",  {16'd0, din_o}, 32'h0);
      check("rst_strw", {31'd0, strw_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);

      // step 1, period 100, eow 20 cycles after each start
      en_i      = 1'b1;
      eow_delay = 20;
      auto_eow  = 1'b1;
      rst_i     = 1'b1;
      tick();
      check("load_busy", {31'd0, busy_o}, 32'd1);
      wait_strw("s1", t0);
      check("s1_din", {16'd0, din_o}, 32'h3800);
      tick();
      check("strw_one_cycle", {31'd0, strw_o}, 32'd0);
      wait_strw("s2", t1);
      check("s2_spacing", t1 - t0, 32'd100);
      check("s2_din", {16'd0, din_o}, 32'h3832);
      t0 = t1;
      wait_strw("s3", t1);
      check("s3_spacing", t1 - t0, 32'd100);
      check("s3_din", {16'd0, din_o}, 32'h3864);

      // en drops in WAIT_EOW: transfer completes, then back to IDLE
      en_i     = 1'b0;
      auto_eow = 1'b0;
      tick(5);
      check("wait_busy", {31'd0, busy_o}, 32'd1);
      check("wait_din_stable", {16'd0, din_o}, 32'h3864);
      eow_i = 1'b1;
      tick();
      eow_i = 1'b0;
      check("hold_busy", {31'd0, busy_o}, 32'd1);
      tick();
      check("idle_busy", {31'd0, busy_o}, 32'd0);
      seen = 0;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (strw_o === 1'b1) seen++;
      end
      check("no_strw_disabled", seen, 32'd0);

      // step 64: quarter-period samples, restart from phase 0
      step_i    = 8'd64;
      eow_timer = 0;
      eow_i     = 1'b0;
      auto_eow  = 1'b1;
      en_i      = 1'b1;
      wait_strw("q1", t0);
      check("q1_din", {16'd0, din_o}, {16'd0, exp_q[0]});
      for (int i = 1; i < 5; i++) begin
         wait_strw("q", t1);
         check("q_spacing", t1 - t0, 32'd100);
         check("q_din", {16'd0, din_o}, {16'd0, exp_q[i]});
         t0 = t1;
      end
      tick();
      period_i = 16'd5;
      wait_strw("q6", t1);
      check("q6_spacing", t1 - t0, 32'd100);
      check("q6_din", {16'd0, din_o}, 32'h3FFF);
      t0 = t1;
      wait_strw("q7", t1);
      check("p5_spacing_a", t1 - t0, 32'd24);
      check("q7_din", {16'd0, din_o}, 32'h3800);
      t0 = t1;
      tick();
      period_i  = 16'd0;
      eow_delay = 1;
      step_i    = 8'd0;
      wait_strw("q8", t1);
      check("p5_spacing_b", t1 - t0, 32'd24);
      check("q8_din", {16'd0, din_o}, 32'h3000);
      t0 = t1;
      wait_strw("q9", t1);
      check("p0_spacing", t1 - t0, 32'd5);
      check("step0_repeat_din", {16'd0, din_o}, 32'h3000);

      // asynchronous reset mid WAIT_EOW, then a stray eow
      auto_eow = 1'b0;
      eow_i    = 1'b0;
      tick(2);
      check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
      #2;
      rst_i = 1'b0;
      #1;
      check("async_rst_strw", {31'd0, strw_o}, 32'd0);
      check("async_rst_busy", {31'd0, busy_o}, 32'd0);
      check("async_rst_din", {16'd0, din_o}, 32'h0);
      tick();
      en_i  = 1'b0;
      rst_i = 1'b1;
      eow_i = 1'b1;
      tick(2);
      eow_i = 1'b0;
      tick(2);
      check("late_eow_busy", {31'd0, busy_o}, 32'd0);
      check("late_eow_strw", {31'd0, strw_o}, 32'd0);

      step_i    = 8'd64;
      period_i  = 16'd100;
      eow_delay = 20;
      eow_timer = 0;
      auto_eow  = 1'b1;
      en_i      = 1'b1;
      wait_strw("r1", t0);
      check("r1_din", {16'd0, din_o}, 32'h3800);

`ifdef SINE_DAC_SEQ_AMP_EN
      tick();
      amp_i = 2'd1;
      wait_strw("a1", t1);
      check("amp_din_64", {16'd0, din_o}, 32'h3BFF);
      wait_strw("a2", t1);
      check("amp_din_128", {16'd0, din_o}, 32'h3800);
      wait_strw("a3", t1);
      check("amp_din_192", {16'd0, din_o}, 32'h3400);
      wait_strw("a4", t1);
      check("amp_din_0", {16'd0, din_o}, 32'h3800);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
